// File: rtl/data_mem_arbiter_pkg.sv
// Shared types and constants for the data_mem arbiter: FSM encoding, requester ids
// and the default memory depth.
package data_mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACCESS   = 2'd1,
        COMPLETE = 2'd2
    } state_e;

    localparam int REQ_REGS      = 0;
    localparam int REQ_ACC       = 1;
    localparam int REQ_PC        = 2;
    localparam int REQ_CRYPTO    = 3;
    localparam int DEPTH_DEFAULT = 400;

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Bus bundle between the requesters, the arbiter and data_mem.
// Handshake: a requester raises req[i] with we/addr/wdata stable and keeps them so until it
// sees its one-cycle ack[i]; err and rdata are meaningful only in that ack cycle.
interface data_mem_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int AW    = 9,
    parameter int DW    = 16
);
    logic [N_REQ-1:0]    req;
    logic [N_REQ-1:0]    we;
    logic [N_REQ*AW-1:0] addr;
    logic [N_REQ*DW-1:0] wdata;
    logic [N_REQ-1:0]    ack;
    logic                err;
    logic [DW-1:0]       rdata;
    logic                busy;
    logic [AW-1:0]       mem_addr;
    logic [DW-1:0]       mem_wdata;
    logic                mem_we;
    logic [DW-1:0]       mem_rdata;
    logic [1:0]          state;

    modport master (
        output req, we, addr, wdata, mem_rdata,
        input  ack, err, rdata, busy, mem_addr, mem_wdata, mem_we, state
    );

    modport slave (
        input  req, we, addr, wdata, mem_rdata,
        output ack, err, rdata, busy, mem_addr, mem_wdata, mem_we, state
    );

endinterface

// File: rtl/data_mem_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_id
);
    int unsigned idx;
    logic        found;

    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = 0;
        for (int i = 0; i < N; i++) begin
            idx = (32'(ptr) + 32'(i)) % 32'(N);
            if (!found && req[idx]) begin
                found       = 1'b1;
                gnt[idx]    = 1'b1;
                gnt_id      = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing the single data_mem port among four requesters; one access
// per IDLE -> ACCESS -> COMPLETE transaction, out-of-range addresses complete with err.
module data_mem_arbiter
    import data_mem_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int AW    = 9,
    parameter int DW    = 16,
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input logic              clk,
    input logic              rst,
    data_mem_arbiter_if.slave bus
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [1:0] S_IDLE     = IDLE;
    localparam logic [1:0] S_ACCESS   = ACCESS;
    localparam logic [1:0] S_COMPLETE = COMPLETE;

    logic [1:0]       state;
    logic [IW-1:0]    rr_ptr;
    logic [IW-1:0]    gnt_id;
    logic [IW-1:0]    next_ptr;
    logic [IW-1:0]    win_id;
    logic [N_REQ-1:0] eligible;
    logic [N_REQ-1:0] gnt;
    logic             lat_we;
    logic             err_pending;
    logic [AW-1:0]    sel_addr;
    logic [DW-1:0]    sel_wdata;
    logic             sel_we;
    logic             sel_in_range;

    // The requester being acked this cycle still has req high; keep it out of the race.
    assign eligible = bus.req & ~bus.ack;

    rr_arbiter #(.N(N_REQ), .IW(IW)) u_rr (
        .req    (eligible),
        .ptr    (rr_ptr),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    assign sel_addr     = bus.addr[int'(gnt_id)*AW +: AW];
    assign sel_wdata    = bus.wdata[int'(gnt_id)*DW +: DW];
    assign sel_we       = bus.we[gnt_id];
    assign sel_in_range = 32'(sel_addr) < 32'(DEPTH);
    assign next_ptr     = (gnt_id == IW'(N_REQ - 1)) ? '0 : gnt_id + 1'b1;

    assign bus.busy  = (state == S_ACCESS) || (state == S_COMPLETE);
    assign bus.state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            rr_ptr        <= '0;
            win_id        <= '0;
            lat_we        <= 1'b0;
            err_pending   <= 1'b0;
            bus.ack       <= '0;
            bus.err       <= 1'b0;
            bus.rdata     <= '0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.mem_we    <= 1'b0;
        end else begin
            bus.ack   <= '0;
            bus.err   <= 1'b0;
            bus.rdata <= '0;
            case (state)
                S_IDLE: begin
                    if (|gnt) begin
                        win_id <= gnt_id;
                        lat_we <= sel_we;
                        rr_ptr <= next_ptr;
                        if (sel_in_range) begin
                            bus.mem_addr  <= sel_addr;
                            bus.mem_wdata <= sel_wdata;
                            bus.mem_we    <= sel_we;
                            err_pending   <= 1'b0;
                            state         <= S_ACCESS;
                        end else begin
                            // Skip ACCESS entirely so data_mem never sees the bad address.
                            err_pending <= 1'b1;
                            state       <= S_COMPLETE;
                        end
                    end
                end
                S_ACCESS: begin
                    bus.mem_we <= 1'b0;
                    state      <= S_COMPLETE;
                end
                S_COMPLETE: begin
                    bus.ack[win_id] <= 1'b1;
                    bus.err         <= err_pending;
                    bus.rdata       <= (!lat_we && !err_pending) ? bus.mem_rdata : '0;
                    state           <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a 400-entry registered-read data_mem model.
module tb_data_mem_arbiter;
    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   we_pulses = 0;

    data_mem_arbiter_if #(.N_REQ(4), .AW(9), .DW(16)) bus ();

    data_mem_arbiter #(.N_REQ(4), .AW(9), .DW(16), .DEPTH(400)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- data_mem model: synchronous write, registered read
    logic [15:0] mem [0:399] = '{default: 16'h0000};

    always @(posedge clk) begin
        if (bus.mem_we === 1'b1) we_pulses++;
        if (bus.mem_we === 1'b1 && int'(bus.mem_addr) < 400)
            mem[int'(bus.mem_addr)] <= bus.mem_wdata;
        bus.mem_rdata <= (int'(bus.mem_addr) < 400) ? mem[int'(bus.mem_addr)] : 16'h0000;
    end

    // ---------------- driver tasks
    task automatic step();
        @(negedge clk);
    endtask

    task automatic drive(input int i, input logic w, input logic [8:0] a, input logic [15:0] d);
        bus.we[i]           = w;
        bus.addr[i*9 +: 9]  = a;
        bus.wdata[i*16 +: 16] = d;
        bus.req[i]          = 1'b1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- directed sequence
    initial begin
        int order [4];
        logic [15:0] exp_rd [4];
        int n_acks;
        bit done;

        rst       = 1'b1;
        bus.req   = '0;
        bus.we    = '0;
        bus.addr  = '0;
        bus.wdata = '0;
        step();
        step();
        chk("rst_ack",       32'(bus.ack), 0);
        chk("rst_err",       32'(bus.err), 0);
        chk("rst_rdata",     32'(bus.rdata), 0);
        chk("rst_busy",      32'(bus.busy), 0);
        chk("rst_mem_we",    32'(bus.mem_we), 0);
        chk("rst_mem_addr",  32'(bus.mem_addr), 0);
        chk("rst_mem_wdata", 32'(bus.mem_wdata), 0);
        chk("rst_state",     32'(bus.state), 0);
        rst = 1'b0;
        step();

        // single write by REGS, then ACC reads it back
        drive(0, 1'b1, 9'd5, 16'hAAAA);
        chk("wr_t0_mem_we", 32'(bus.mem_we), 0);
        step();
        chk("wr_t1_mem_we",    32'(bus.mem_we), 1);
        chk("wr_t1_mem_addr",  32'(bus.mem_addr), 5);
        chk("wr_t1_mem_wdata", 32'(bus.mem_wdata), 32'hAAAA);
        chk("wr_t1_state",     32'(bus.state), 1);
        chk("wr_t1_ack",       32'(bus.ack), 0);
        step();
        chk("wr_t2_mem_we", 32'(bus.mem_we), 0);
        chk("wr_t2_busy",   32'(bus.busy), 1);
        chk("wr_t2_state",  32'(bus.state), 2);
        chk("wr_t2_ack",    32'(bus.ack), 0);
        step();
        chk("wr_t3_ack",   32'(bus.ack), 32'b0001);
        chk("wr_t3_err",   32'(bus.err), 0);
        chk("wr_t3_rdata", 32'(bus.rdata), 0);
        chk("wr_t3_busy",  32'(bus.busy), 0);
        bus.req[0] = 1'b0;
        drive(1, 1'b0, 9'd5, 16'h0000);
        step();
        step();
        step();
        chk("rd_ack",   32'(bus.ack), 32'b0010);
        chk("rd_rdata", 32'(bus.rdata), 32'hAAAA);
        chk("rd_err",   32'(bus.err), 0);
        bus.req[1] = 1'b0;
        step();
        chk("rd_after_ack", 32'(bus.ack), 0);
        chk("rd_after_busy", 32'(bus.busy), 0);

        // CRYPTO: out-of-range read, then last valid address
        drive(3, 1'b0, 9'd400, 16'h0000);
        step();
        chk("oor_state",  32'(bus.state), 2);
        chk("oor_mem_we", 32'(bus.mem_we), 0);
        step();
        chk("oor_ack",    32'(bus.ack), 32'b1000);
        chk("oor_err",    32'(bus.err), 1);
        chk("oor_rdata",  32'(bus.rdata), 0);
        chk("oor_mem_we2", 32'(bus.mem_we), 0);
        bus.req[3] = 1'b0;
        step();
        drive(3, 1'b1, 9'd399, 16'h1234);
        step();
        step();
        step();
        chk("a399_ack", 32'(bus.ack), 32'b1000);
        chk("a399_err", 32'(bus.err), 0);
        bus.req[3] = 1'b0;
        step();

        // all four at once, rr_ptr = 0
        drive(0, 1'b1, 9'd10, 16'h1111);
        drive(1, 1'b1, 9'd11, 16'h2222);
        drive(2, 1'b0, 9'd5,  16'h0000);
        drive(3, 1'b0, 9'd10, 16'h0000);
        exp_rd = '{16'h0000, 16'h0000, 16'hAAAA, 16'h1111};
        for (int k = 0; k < 4; k++) begin
            step();
            step();
            step();
            chk($sformatf("all4_ack_%0d", k),   32'(bus.ack), 32'(1 << k));
            chk($sformatf("all4_rdata_%0d", k), 32'(bus.rdata), 32'(exp_rd[k]));
            chk($sformatf("all4_err_%0d", k),   32'(bus.err), 0);
            bus.req[k] = 1'b0;
        end
        step();

        // pointer back at 0: REGS beats ACC
        drive(0, 1'b0, 9'd10, 16'h0000);
        drive(1, 1'b0, 9'd11, 16'h0000);
        step();
        step();
        step();
        chk("ptr0_ack_regs", 32'(bus.ack), 32'b0001);
        chk("ptr0_rdata_regs", 32'(bus.rdata), 32'h1111);
        bus.req[0] = 1'b0;
        step();
        step();
        step();
        chk("ptr0_ack_acc", 32'(bus.ack), 32'b0010);
        chk("ptr0_rdata_acc", 32'(bus.rdata), 32'h2222);
        bus.req[1] = 1'b0;
        step();

        // ack masking: PC keeps req through its ack cycle while ACC waits
        drive(2, 1'b0, 9'd399, 16'h0000);
        drive(1, 1'b0, 9'd11,  16'h0000);
        step();
        step();
        step();
        chk("mask_pc_ack",   32'(bus.ack), 32'b0100);
        chk("mask_pc_rdata", 32'(bus.rdata), 32'h1234);
        step();
        bus.req[2] = 1'b0;
        step();
        step();
        chk("mask_acc_ack",   32'(bus.ack), 32'b0010);
        chk("mask_acc_rdata", 32'(bus.rdata), 32'h2222);
        bus.req[1] = 1'b0;
        step();

        // ack masking with PC alone: no duplicate grant in the ack cycle
        drive(2, 1'b0, 9'd5, 16'h0000);
        step();
        step();
        step();
        chk("solo_pc_ack",   32'(bus.ack), 32'b0100);
        chk("solo_pc_rdata", 32'(bus.rdata), 32'hAAAA);
        step();
        chk("solo_no_regrant_state", 32'(bus.state), 0);
        bus.req[2] = 1'b0;
        step();
        step();
        chk("solo_no_dup_ack", 32'(bus.ack), 0);

        // reset during ACCESS of a write to 7
        drive(0, 1'b1, 9'd7, 16'hBEEF);
        step();
        chk("rmid_state",  32'(bus.state), 1);
        chk("rmid_mem_we", 32'(bus.mem_we), 1);
        rst = 1'b1;
        #1;
        chk("rmid_async_mem_we",    32'(bus.mem_we), 0);
        chk("rmid_async_state",     32'(bus.state), 0);
        chk("rmid_async_busy",      32'(bus.busy), 0);
        chk("rmid_async_mem_addr",  32'(bus.mem_addr), 0);
        chk("rmid_async_mem_wdata", 32'(bus.mem_wdata), 0);
        chk("rmid_async_ack",       32'(bus.ack), 0);
        bus.req[0] = 1'b0;
        step();
        rst = 1'b0;
        step();
        step();
        step();
        chk("rmid_no_ack",  32'(bus.ack), 0);
        chk("rmid_no_busy", 32'(bus.busy), 0);
        drive(0, 1'b0, 9'd7, 16'h0000);
        step();
        step();
        step();
        chk("rmid_rd7_ack",   32'(bus.ack), 32'b0001);
        chk("rmid_rd7_rdata", 32'(bus.rdata), 0);
        bus.req[0] = 1'b0;
        step();

        // stall: everyone requests continuously, rr_ptr = 1, REGS must come 4th
        drive(0, 1'b0, 9'd5,   16'h0000);
        drive(1, 1'b0, 9'd11,  16'h0000);
        drive(2, 1'b0, 9'd10,  16'h0000);
        drive(3, 1'b0, 9'd399, 16'h0000);
        order  = '{1, 2, 3, 0};
        exp_rd = '{16'hAAAA, 16'h2222, 16'h1111, 16'h1234};
        n_acks = 0;
        done   = 1'b0;
        for (int c = 0; c < 20 && !done && n_acks < 4; c++) begin
            step();
            if (bus.ack !== 4'b0000) begin
                chk($sformatf("stall_ack_%0d", n_acks), 32'(bus.ack), 32'(1 << order[n_acks]));
                chk($sformatf("stall_rdata_%0d", n_acks), 32'(bus.rdata),
                    32'(exp_rd[order[n_acks]]));
                n_acks++;
                if (bus.ack[0] === 1'b1) begin
                    done    = 1'b1;
                    bus.req = '0;
                end
            end
        end
        chk("stall_regs_acked", 32'(done), 1);
        chk("stall_n_acks",     32'(n_acks), 4);
        bus.req = '0;
        step();
        step();
        step();
        chk("total_we_pulses", 32'(we_pulses), 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
